mmio_bridge: RTL and testbench

Data-side address decoder between the RISC core's data port and the data RAM. It routes word accesses either to the RAM or to a small memory-mapped I/O register file. The register file covers LEDs, six seven-segment displays, slide switches and push-buttons. It returns read data with the same one-cycle latency as the RAM, so the core sees a single uniform data bus.

---
 rtl/mmio_bridge.sv | 139 +++++++++++++
 tb/tb_mmio_bridge.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mmio_bridge.sv
// Data-side decoder: address bit 31 steers word accesses to the data RAM or to an LED/HEX/SW/KEY register file.
// Latency: RAM path combinational; I/O reads registered so both targets return data one cycle after the address.
// No backpressure: one access per cycle; KEY_EDGE register (W1C) is built only when KEY_EDGE_EN is defined.
module mmio_bridge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cpu_address,
    input  logic [31:0] cpu_wdata,
    input  logic        cpu_we,
    output logic [31:0] cpu_rdata,
    output logic        cpu_rdata_valid,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    output logic        ram_we,
    input  logic [31:0] ram_rdata,
    input  logic        ram_rdata_valid,
    input  logic [9:0]  sw,
    input  logic [3:0]  key,
    output logic [9:0]  ledr,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [6:0]  hex4,
    output logic [6:0]  hex5
);
    logic                        io_sel;
    logic [2:0]                  idx;
    logic                        io_we;
    logic [9:0]                  ledr_q;
    logic [23:0]                 hex_q;
    logic [SYNC_STAGES-1:0][9:0] sw_sync;
    logic [SYNC_STAGES-1:0][3:0] key_sync;
    logic [9:0]                  sw_s;
    logic [3:0]                  key_s;
    logic [3:0]                  key_edge_rd;
    logic [31:0]                 io_rdata_d;
    logic [31:0]                 io_rdata_q;
    logic                        sel_q;
    logic                        valid_en;
    logic                        unused_addr_bits;

    assign io_sel    = cpu_address[31];
    assign idx       = cpu_address[4:2];
    assign io_we     = cpu_we & io_sel;
    assign ram_addr  = cpu_address;
    assign ram_wdata = cpu_wdata;
    assign ram_we    = cpu_we & ~io_sel;
    assign unused_addr_bits = ^{cpu_address[30:5], cpu_address[1:0]};

    assign sw_s  = sw_sync[SYNC_STAGES-1];
    assign key_s = key_sync[SYNC_STAGES-1];

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
        endcase
    endfunction

    assign ledr = ledr_q;
    assign hex0 = hex7(hex_q[3:0]);
    assign hex1 = hex7(hex_q[7:4]);
    assign hex2 = hex7(hex_q[11:8]);
    assign hex3 = hex7(hex_q[15:12]);
    assign hex4 = hex7(hex_q[19:16]);
    assign hex5 = hex7(hex_q[23:20]);

    // Keys idle high (released), so the synchroniser resets to all-ones to avoid a false press.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_sync  <= '0;
            key_sync <= {SYNC_STAGES{4'hF}};
        end else begin
            sw_sync  <= {sw_sync[SYNC_STAGES-2:0], sw};
            key_sync <= {key_sync[SYNC_STAGES-2:0], key};
        end
    end

`ifdef KEY_EDGE_EN
    logic [3:0] key_prev;
    logic [3:0] key_edge_q;
    logic [3:0] edge_set;
    logic [3:0] edge_clr;

    assign edge_set    = key_prev & ~key_s;
    assign edge_clr    = (io_we && idx == 3'd4) ? cpu_wdata[3:0] : 4'h0;
    assign key_edge_rd = key_edge_q;

    // Set is OR-ed after the clear so a press coinciding with W1C is not lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_prev   <= 4'hF;
            key_edge_q <= 4'h0;
        end else begin
            key_prev   <= key_s;
            key_edge_q <= (key_edge_q & ~edge_clr) | edge_set;
        end
    end
`else
    assign key_edge_rd = 4'h0;
`endif

    always_comb begin
        io_rdata_d = '0;
        case (idx)
            3'd0: io_rdata_d[9:0]  = ledr_q;
            3'd1: io_rdata_d[23:0] = hex_q;
            3'd2: io_rdata_d[9:0]  = sw_s;
            3'd3: io_rdata_d[3:0]  = ~key_s;
            3'd4: io_rdata_d[3:0]  = key_edge_rd;
            default: io_rdata_d = '0;
        endcase
    end

    // The read mux samples pre-write values, so a same-cycle write/read returns the old contents.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ledr_q     <= '0;
            hex_q      <= '0;
            io_rdata_q <= '0;
            sel_q      <= 1'b0;
            valid_en   <= 1'b0;
        end else begin
            if (io_we && idx == 3'd0) ledr_q <= cpu_wdata[9:0];
            if (io_we && idx == 3'd1) hex_q  <= cpu_wdata[23:0];
            io_rdata_q <= io_rdata_d;
            sel_q      <= io_sel;
            valid_en   <= 1'b1;
        end
    end

    assign cpu_rdata       = sel_q ? io_rdata_q : ram_rdata;
    assign cpu_rdata_valid = valid_en & (sel_q | ram_rdata_valid);
endmodule

// File: tb/tb_mmio_bridge.sv
// Directed bench for mmio_bridge: register map, RAM routing, synchroniser latency, key edges, reset.
module tb_mmio_bridge;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] cpu_address;
    logic [31:0] cpu_wdata;
    logic        cpu_we;
    logic [31:0] cpu_rdata;
    logic        cpu_rdata_valid;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic        ram_we;
    logic [31:0] ram_rdata;
    logic        ram_rdata_valid;
    logic [9:0]  sw;
    logic [3:0]  key;
    logic [9:0]  ledr;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;

    int n_checks = 0;
    int n_pass   = 0;

    mmio_bridge #(.SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset),
        .cpu_address(cpu_address), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
        .cpu_rdata(cpu_rdata), .cpu_rdata_valid(cpu_rdata_valid),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
        .ram_rdata(ram_rdata), .ram_rdata_valid(ram_rdata_valid),
        .sw(sw), .key(key), .ledr(ledr),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5)
    );

    always #5 clk = ~clk;

    // Simple RAM stand-in: data is a known function of the address, one cycle later.
    always @(posedge clk) begin
        ram_rdata       <= ram_addr ^ 32'hA5A5_0000;
        ram_rdata_valid <= !ram_we;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Tasks start and end 1 time unit after a rising edge.
    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        cpu_address = addr;
        cpu_wdata   = data;
        cpu_we      = 1'b1;
        @(posedge clk); #1;
        cpu_we      = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data, output logic vld);
        cpu_address = addr;
        cpu_we      = 1'b0;
        @(posedge clk); #1;
        data = cpu_rdata;
        vld  = cpu_rdata_valid;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    logic [31:0] rd;
    logic        vld;

    initial begin
        reset = 1'b1; cpu_address = '0; cpu_wdata = '0; cpu_we = 1'b0;
        sw = '0; key = 4'hF;
        repeat (2) @(posedge clk); #1;
        check("rst_ledr", {22'b0, ledr}, 32'h0);
        check("rst_hex0", {25'b0, hex0}, 32'h40);
        check("rst_hex5", {25'b0, hex5}, 32'h40);
        check("rst_valid", {31'b0, cpu_rdata_valid}, 32'h0);
        reset = 1'b0;
        #1 check("rel_valid_c1", {31'b0, cpu_rdata_valid}, 32'h0);
        idle(1);
        check("rel_valid_c2", {31'b0, cpu_rdata_valid}, 32'h1);

        // HEX register: decode and read-back, upper bits read zero
        bus_write(32'h8000_0004, 32'h00FE_DCBA);
        check("hex0_A", {25'b0, hex0}, 32'h08);
        check("hex1_B", {25'b0, hex1}, 32'h03);
        check("hex2_C", {25'b0, hex2}, 32'h46);
        check("hex3_D", {25'b0, hex3}, 32'h21);
        check("hex4_E", {25'b0, hex4}, 32'h06);
        check("hex5_F", {25'b0, hex5}, 32'h0E);
        bus_read(32'h8000_0004, rd, vld);
        check("hex_rd", rd, 32'h00FE_DCBA);
        check("hex_rd_vld", {31'b0, vld}, 32'h1);
        bus_write(32'h8000_0004, 32'hFFFF_FF98);
        check("hex0_8", {25'b0, hex0}, 32'h00);
        check("hex1_9", {25'b0, hex1}, 32'h10);
        bus_read(32'h8000_0004, rd, vld);
        check("hex_upper0", rd, 32'h00FF_FF98);

        // RAM routing vs I/O routing
        cpu_address = 32'h0000_0010; cpu_wdata = 32'h1234_5678; cpu_we = 1'b1;
        #1;
        check("ram_we_ram", {31'b0, ram_we}, 32'h1);
        check("ram_addr", ram_addr, 32'h0000_0010);
        check("ram_wdata", ram_wdata, 32'h1234_5678);
        @(posedge clk); #1;
        cpu_address = 32'h8000_0000; cpu_wdata = 32'h0000_0001;
        #1;
        check("ram_we_io", {31'b0, ram_we}, 32'h0);
        @(posedge clk); #1;
        cpu_we = 1'b0;
        check("ledr_1", {22'b0, ledr}, 32'h1);
        bus_read(32'h0000_0010, rd, vld);
        check("ram_rd", rd, 32'hA5A5_0010);
        check("ram_rd_vld", {31'b0, vld}, 32'h1);

        // Same-cycle write returns old value, next cycle new
        bus_write(32'h8000_0000, 32'h0000_002A);
        check("ledr_old", cpu_rdata, 32'h1);
        bus_read(32'h8000_0000, rd, vld);
        check("ledr_new", rd, 32'h2A);

        // Switch synchroniser latency (2 stages + read register)
        cpu_address = 32'h8000_0008; sw = 10'h2A5;
        idle(2);
        check("sw_early", cpu_rdata, 32'h0);
        idle(1);
        check("sw_sync", cpu_rdata, 32'h2A5);
        bus_write(32'h8000_0008, 32'h0000_03FF);
        bus_read(32'h8000_0008, rd, vld);
        check("sw_ro", rd, 32'h2A5);

        // Keys: level register and edge flags
        key = 4'hB;
        idle(4);
        bus_read(32'h8000_000C, rd, vld);
        check("key_lvl", rd, 32'h4);
`ifdef KEY_EDGE_EN
        bus_read(32'h8000_0010, rd, vld);
        check("edge_set", rd, 32'h4);
        bus_write(32'h8000_0010, 32'h4);
        bus_read(32'h8000_0010, rd, vld);
        check("edge_w1c", rd, 32'h0);
        key = 4'hF;
        idle(4);
        key = 4'hB;
        idle(2);
        bus_write(32'h8000_0010, 32'h4);
        bus_read(32'h8000_0010, rd, vld);
        check("edge_set_wins", rd, 32'h4);
        bus_write(32'h8000_0010, 32'h0);
        bus_read(32'h8000_0010, rd, vld);
        check("edge_w0_keep", rd, 32'h4);
        bus_write(32'h8000_0010, 32'h4);
        bus_read(32'h8000_0010, rd, vld);
        check("edge_clr", rd, 32'h0);
`else
        bus_read(32'h8000_0010, rd, vld);
        check("edge_absent", rd, 32'h0);
        check("edge_absent_vld", {31'b0, vld}, 32'h1);
`endif
        key = 4'hF;

        // Unmapped space
        bus_write(32'h8000_0014, 32'hFFFF_FFFF);
        bus_read(32'h8000_0014, rd, vld);
        check("unmap14", rd, 32'h0);
        bus_read(32'h8000_0018, rd, vld);
        check("unmap18", rd, 32'h0);
        check("unmap18_vld", {31'b0, vld}, 32'h1);

        // Mid-run reset
        bus_write(32'h8000_0000, 32'h0000_03FF);
        check("ledr_3ff", {22'b0, ledr}, 32'h3FF);
        reset = 1'b1;
        #1;
        check("mid_rst_ledr", {22'b0, ledr}, 32'h0);
        check("mid_rst_hex0", {25'b0, hex0}, 32'h40);
        check("mid_rst_hex5", {25'b0, hex5}, 32'h40);
        check("mid_rst_valid", {31'b0, cpu_rdata_valid}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        #1 check("mid_rel_c1", {31'b0, cpu_rdata_valid}, 32'h0);
        @(posedge clk); #1;
        check("mid_rel_c2", {31'b0, cpu_rdata_valid}, 32'h1);
        check("mid_rel_rd", cpu_rdata, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
